mac_vlg_tx_arb: RTL

- Frame-level round-robin arbiter that sits directly upstream of the MAC TX stage.
- Merges N_SRC client byte streams (e.g. ARP, IPv4) into the single TX stream that the MAC transmitter consumes.
- Locks the grant for a whole frame, latches the frame header on the first beat, and guards against stalled clients with a timeout-abort.
- Single local clock domain (the same clk as the MAC TX path).

---
 rtl/mac_vlg_tx_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_vlg_tx_arb.sv
// mac_vlg_tx_arb: frame-level round-robin arbiter feeding the MAC TX stage.
// Define MAC_VLG_TX_ARB_STAT_EN to add per-client frame and abort counters.
module mac_vlg_tx_arb #(
    parameter int N_SRC   = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*N_SRC-1:0]  src_dat,
    input  logic [N_SRC-1:0]    src_val,
    input  logic [N_SRC-1:0]    src_sof,
    input  logic [N_SRC-1:0]    src_eof,
    input  logic [64*N_SRC-1:0] src_hdr,
    output logic [N_SRC-1:0]    src_rdy,
    output logic [7:0]          tx_dat,
    output logic                tx_val,
    output logic                tx_sof,
    output logic                tx_eof,
    output logic                tx_err,
    output logic [63:0]         tx_hdr,
    input  logic                tx_rdy,
    output logic [N_SRC-1:0]    gnt
`ifdef MAC_VLG_TX_ARB_STAT_EN
    ,
    output logic [16*N_SRC-1:0] stat_frm,
    output logic [15:0]         stat_abort
`endif
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            first_q, first_d;
    logic [7:0]      tx_dat_q, tx_dat_d;
    logic            tx_val_q, tx_val_d;
    logic            tx_sof_q, tx_sof_d;
    logic            tx_eof_q, tx_eof_d;
    logic            tx_err_q, tx_err_d;
    logic [63:0]     tx_hdr_q, tx_hdr_d;

    logic             free;
    logic             accept;
    logic [7:0]       sel_dat;
    logic             sel_sof;
    logic             sel_eof;
    logic [63:0]      sel_hdr;
    logic [N_SRC-1:0] cand;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW:0]      scan_idx;

    assign free    = !tx_val_q || tx_rdy;
    assign sel_dat = src_dat[gnt_idx_q*8 +: 8];
    assign sel_sof = src_sof[gnt_idx_q];
    assign sel_eof = src_eof[gnt_idx_q];
    assign sel_hdr = src_hdr[gnt_idx_q*64 +: 64];
    // DRAIN consumes regardless of the output slice, since nothing is forwarded.
    assign src_rdy = gnt_q & {N_SRC{(state_q == XFER && free) || state_q == DRAIN}};
    assign accept  = |(src_rdy & src_val);
    assign cand    = src_val & src_sof;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = {1'b0, rr_q} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(N_SRC)) scan_idx = scan_idx - (IW+1)'(N_SRC);
            if (!pick_found && cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rr_d      = rr_q;
        to_cnt_d  = to_cnt_q;
        first_d   = first_q;
        tx_dat_d  = tx_dat_q;
        tx_val_d  = tx_val_q;
        tx_sof_d  = tx_sof_q;
        tx_eof_d  = tx_eof_q;
        tx_err_d  = tx_err_q;
        tx_hdr_d  = tx_hdr_q;
        if (free) begin
            tx_val_d = 1'b0;
            tx_sof_d = 1'b0;
            tx_eof_d = 1'b0;
            tx_err_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = XFER;
                    gnt_d     = N_SRC'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                    rr_d      = (pick_idx == IW'(N_SRC-1)) ? '0 : pick_idx + 1'b1;
                    to_cnt_d  = '0;
                    first_d   = 1'b1;
                end
            end
            XFER: begin
                if (accept) begin
                    tx_val_d = 1'b1;
                    tx_dat_d = sel_dat;
                    tx_sof_d = sel_sof;
                    tx_eof_d = sel_eof;
                    tx_err_d = 1'b0;
                    to_cnt_d = '0;
                    first_d  = 1'b0;
                    // Only the opening sof of the frame owns the header.
                    if (first_q && sel_sof) tx_hdr_d = sel_hdr;
                    if (sel_eof) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (free && to_cnt_q >= TO_W'(TIMEOUT-1)) begin
                    tx_val_d = 1'b1;
                    tx_dat_d = 8'h00;
                    tx_sof_d = 1'b0;
                    tx_eof_d = 1'b1;
                    tx_err_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = DRAIN;
                end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (accept && sel_eof) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_q      <= '0;
            to_cnt_q  <= '0;
            first_q   <= 1'b0;
            tx_dat_q  <= 8'h00;
            tx_val_q  <= 1'b0;
            tx_sof_q  <= 1'b0;
            tx_eof_q  <= 1'b0;
            tx_err_q  <= 1'b0;
            tx_hdr_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_q      <= rr_d;
            to_cnt_q  <= to_cnt_d;
            first_q   <= first_d;
            tx_dat_q  <= tx_dat_d;
            tx_val_q  <= tx_val_d;
            tx_sof_q  <= tx_sof_d;
            tx_eof_q  <= tx_eof_d;
            tx_err_q  <= tx_err_d;
            tx_hdr_q  <= tx_hdr_d;
        end
    end

    assign tx_dat = tx_dat_q;
    assign tx_val = tx_val_q;
    assign tx_sof = tx_sof_q;
    assign tx_eof = tx_eof_q;
    assign tx_err = tx_err_q;
    assign tx_hdr = tx_hdr_q;
    assign gnt    = gnt_q;

`ifdef MAC_VLG_TX_ARB_STAT_EN
    logic [IW-1:0] out_src_q;
    logic [15:0]   abort_q;
    logic          tx_done;

    assign tx_done = tx_val_q && tx_rdy && tx_eof_q;

    // Remembers which client owns the beat currently held in the output slice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_src_q <= '0;
            abort_q   <= '0;
        end else begin
            if (free) out_src_q <= gnt_idx_q;
            if (tx_done && tx_err_q) abort_q <= abort_q + 16'd1;
        end
    end

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_stat
        logic [15:0] frm_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) frm_q <= '0;
            else if (tx_done && !tx_err_q && out_src_q == IW'(gi)) frm_q <= frm_q + 16'd1;
        end
        assign stat_frm[gi*16 +: 16] = frm_q;
    end

    assign stat_abort = abort_q;
`endif

endmodule
